// File: rtl/operand_encoder_pkg.sv
// Shared SPARC field constants, widths and FSM state encoding for the operand encoder.
package operand_encoder_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM22_W  = 22;
  localparam int unsigned SIMM13_W = 13;

  localparam logic [1:0] OP_FMT2   = 2'b00;
  localparam logic [1:0] OP_FMT3   = 2'b10;
  localparam logic [2:0] OP2_SETHI = 3'b100;
  localparam logic [5:0] OP3_OR    = 6'b000010;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EMIT_SETHI = 2'd1,
    EMIT_OR    = 2'd2
  } state_e;

endpackage

// File: rtl/sparc_fmt_pack.sv
// Combinational SPARC word formatter: builds SETHI and OR-immediate words from their fields.
module sparc_fmt_pack
  import operand_encoder_pkg::*;
(
  input  logic [REG_W-1:0]    rd_i,
  input  logic [REG_W-1:0]    rs1_i,
  input  logic [IMM22_W-1:0]  imm22_i,
  input  logic [SIMM13_W-1:0] simm13_i,
  output logic [WORD_W-1:0]   sethi_word_o,
  output logic [WORD_W-1:0]   or_word_o
);

  assign sethi_word_o = {OP_FMT2, rd_i, OP2_SETHI, imm22_i};
  assign or_word_o    = {OP_FMT3, rd_i, OP3_OR, rs1_i, 1'b1, simm13_i};

endmodule

// File: rtl/operand_encoder.sv
// Materializes a 32-bit constant into a SETHI / OR-immediate sequence with valid/ready handshakes.
// Optional macro OPERAND_ENC_SIMM13_EN: constants fitting simm13 are emitted as a single OR %g0 word.
module operand_encoder
  import operand_encoder_pkg::*;
#(
  parameter bit ZERO_RD_DROP = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_value,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic              out_last,
  output logic              busy
);

  state_e              state_q;
  logic [WORD_W-1:0]   value_q;
  logic [REG_W-1:0]    rd_q;
  logic                out_valid_q;
  logic [WORD_W-1:0]   out_instr_q;
  logic                out_last_q;
  logic                busy_q;

  logic                idle;
  logic [WORD_W-1:0]   src_value;
  logic [REG_W-1:0]    src_rd;
  logic [REG_W-1:0]    fmt_rs1;
  logic [SIMM13_W-1:0] fmt_simm13;
  logic [WORD_W-1:0]   sethi_word;
  logic [WORD_W-1:0]   or_word;
  logic                simm13_fit;

  assign idle     = (state_q == IDLE);
  assign in_ready = idle && !reset;

  // In IDLE the first word is built straight from the request; later words use the captured copy.
  assign src_value  = idle ? in_value : value_q;
  assign src_rd     = idle ? in_rd    : rd_q;
  assign fmt_rs1    = idle ? REG_W'(0) : rd_q;
  assign fmt_simm13 = idle ? src_value[SIMM13_W-1:0]
                           : {3'b000, src_value[9:0]};

`ifdef OPERAND_ENC_SIMM13_EN
  assign simm13_fit = (in_value[31:12] == 20'h00000) || (&in_value[31:12]);
`else
  assign simm13_fit = 1'b0;
`endif

  sparc_fmt_pack u_fmt (
    .rd_i         (src_rd),
    .rs1_i        (fmt_rs1),
    .imm22_i      (src_value[31:10]),
    .simm13_i     (fmt_simm13),
    .sethi_word_o (sethi_word),
    .or_word_o    (or_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      value_q     <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            value_q <= in_value;
            rd_q    <= in_rd;
            if (ZERO_RD_DROP && (in_rd == REG_W'(0))) begin
              state_q <= IDLE;
            end else if (simm13_fit) begin
              state_q     <= EMIT_OR;
              out_valid_q <= 1'b1;
              out_instr_q <= or_word;
              out_last_q  <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              state_q     <= EMIT_SETHI;
              out_valid_q <= 1'b1;
              out_instr_q <= sethi_word;
              out_last_q  <= (in_value[9:0] == 10'd0);
              busy_q      <= 1'b1;
            end
          end
        end
        EMIT_SETHI: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              state_q     <= EMIT_OR;
              out_instr_q <= or_word;
              out_last_q  <= 1'b1;
            end
          end
        end
        EMIT_OR: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule
